axi4_lite_master: RTL and testbench

Single-outstanding AXI4-Lite initiator that turns one-word read/write commands from the DMA engine into AXI4-Lite bus transactions. It drives the write phases strictly in order (AW, then W, then B) and handles reads as AR then R. A per-phase timeout keeps a non-responding slave from hanging the DMA datapath. It sits between the DMA channel sequencer and the system AXI4-Lite interconnect or memory slave.

---
 rtl/axi4_lite_master.sv | 197 +++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one DMA read/write command into one
// AXI4-Lite transaction, with a per-phase wait limit that completes with an error flag.
module axi4_lite_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic TMO_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              err_d;
    logic              tmo_s;
    logic              acc_s;
    logic              rcap_s;

    logic              cmd_ready_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [DATA_W-1:0] wdata_q;

    assign tmo_s  = TMO_EN && (timer_q == TMO_LAST);
    assign acc_s  = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign rcap_s = (state_q == RD_DATA) && RVALID;

    // Next-state logic; a handshake always takes priority over an expiring timer.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_s) begin
                    state_d = cmd_write ? WR_ADDR : RD_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_ADDR: begin
                if (AWREADY) begin
                    state_d = WR_DATA;
                end else if (tmo_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (WREADY) begin
                    state_d = WR_RESP;
                end else if (tmo_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    state_d = DONE;
                end else if (tmo_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (ARREADY) begin
                    state_d = RD_DATA;
                end else if (tmo_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    state_d = DONE;
                end else if (tmo_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = RD_DATA;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase wait counter: restarts on every state change, idle outside bus phases.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    // State, handshake flags decoded from the next state, and latched command/response data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_ready_q <= (state_d == IDLE);
            awvalid_q   <= (state_d == WR_ADDR);
            wvalid_q    <= (state_d == WR_DATA);
            bready_q    <= (state_d == WR_RESP);
            arvalid_q   <= (state_d == RD_ADDR);
            rready_q    <= (state_d == RD_DATA);
            rsp_valid_q <= (state_d == DONE);
            rsp_err_q   <= (state_d == DONE) && err_d;
            if (rcap_s) begin
                rdata_q <= RDATA;
            end
            if (acc_s && cmd_write) begin
                awaddr_q <= cmd_addr;
                wdata_q  <= cmd_wdata;
            end
            if (acc_s && !cmd_write) begin
                araddr_q <= cmd_addr;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign AWADDR    = awaddr_q;
    assign ARADDR    = araddr_q;
    assign WDATA     = wdata_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: configurable-latency AXI4-Lite slave plus a reference
// model predicting read data, error flag and completion latency of each command.
module tb_axi4_lite_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
    logic [31:0] RDATA = 32'd0;

    int total = 0;
    int bad   = 0;

    int aw_dly = 1, w_dly = 1, b_dly = 0, ar_dly = 1, r_dly = 0;
    bit w_pre = 1'b0, ar_never = 1'b0, w_never = 1'b0;

    int rsp_cnt = 0, wv_cyc = 0, arv_cyc = 0, wbeats = 0, overlap = 0, awaddr_chg = 0;
    logic [31:0] slv_mem [logic [31:0]];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_rdata = 32'd0;

    axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    // Completion latency in cycles after the accept edge: each phase costs its wait plus one.
    function automatic int exp_lat(input bit wr);
        if (wr) return (aw_dly + 1) + (w_pre ? 1 : w_dly + 1) + (b_dly + 1) + 1;
        if (ar_never) return TMO + 1;
        return (ar_dly + 1) + (r_dly + 1) + 1;
    endfunction

    // Slave: samples handshakes on the falling edge, updates its outputs just after the rising edge.
    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_prev, b_pend, r_pend;
        logic [31:0] s_awaddr, s_wdata, s_araddr, aw_seen;
        int aw_w, w_w, ar_w, b_w, r_w;
        aw_prev = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        s_awaddr = 32'd0; s_wdata = 32'd0; s_araddr = 32'd0; aw_seen = 32'd0;
        aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
        slv_mem[32'h1104] = 32'h55667788;
        slv_mem[32'h1304] = 32'h55555555;
        forever begin
            @(negedge clk);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            if (rsp_valid) rsp_cnt++;
            if (AWVALID && WVALID) overlap++;
            if (WVALID) wv_cyc++;
            if (ARVALID) arv_cyc++;
            if (AWVALID && aw_prev && (AWADDR !== aw_seen)) awaddr_chg++;
            aw_prev = AWVALID;
            aw_seen = AWADDR;
            if (aw_hs) s_awaddr = AWADDR;
            if (w_hs) begin s_wdata = WDATA; wbeats++; end
            if (b_hs) slv_mem[s_awaddr] = s_wdata;
            if (ar_hs) s_araddr = ARADDR;
            @(posedge clk);
            #1;
            if (AWVALID) begin AWREADY = (aw_w >= aw_dly); aw_w++; end
            else begin AWREADY = 1'b0; aw_w = 0; end
            if (WVALID) begin WREADY = !w_never && (w_pre || (w_w >= w_dly)); w_w++; end
            else begin WREADY = w_pre; w_w = 0; end
            if (ARVALID) begin ARREADY = !ar_never && (ar_w >= ar_dly); ar_w++; end
            else begin ARREADY = 1'b0; ar_w = 0; end
            if (w_hs) begin b_pend = 1'b1; b_w = 0; end
            if (b_hs) b_pend = 1'b0;
            if (ar_hs) begin r_pend = 1'b1; r_w = 0; end
            if (r_hs) r_pend = 1'b0;
            if (!reset) begin b_pend = 1'b0; r_pend = 1'b0; end
            BVALID = b_pend && (b_w >= b_dly);
            if (b_pend) b_w++;
            RVALID = r_pend && (r_w >= r_dly);
            RDATA  = RVALID ? (slv_mem.exists(s_araddr) ? slv_mem[s_awaddr == s_awaddr ? s_araddr : s_araddr] : 32'd0)
                            : $urandom;
            if (r_pend) r_w++;
        end
    end

    // Issue one command from an IDLE falling edge and check its completion against the model.
    task automatic run_cmd(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n, lat, rsp0, wv0, arv0, wb0, ov0, ac0;
        bit busy_bad, exp_er;
        logic [31:0] exp_rd;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, ":cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        rsp0 = rsp_cnt; wv0 = wv_cyc; arv0 = arv_cyc; wb0 = wbeats; ov0 = overlap; ac0 = awaddr_chg;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        lat = 1;
        busy_bad = 1'b0;
        while (!rsp_valid && lat < 100) begin
            if (cmd_ready) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        exp_er = !wr && ar_never;
        if (wr || exp_er) begin
            exp_rd = last_rdata;
        end else begin
            exp_rd = ref_read(a);
        end
        last_rdata = exp_rd;
        if (wr) ref_mem[a] = d;
        chk({tag, ":latency"}, 64'(lat), 64'(exp_lat(wr)));
        chk({tag, ":rsp_err"}, 64'(rsp_err), 64'(exp_er));
        chk({tag, ":rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        chk({tag, ":cmd_ready_busy"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk({tag, ":rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
        chk({tag, ":rsp_pulses"}, 64'(rsp_cnt - rsp0), 64'd1);
        chk({tag, ":aw_w_overlap"}, 64'(overlap - ov0), 64'd0);
        chk({tag, ":awaddr_stable"}, 64'(awaddr_chg - ac0), 64'd0);
        chk({tag, ":w_beats"}, 64'(wbeats - wb0), 64'(wr));
        chk({tag, ":wvalid_cycles"}, 64'(wv_cyc - wv0), wr ? 64'(w_pre ? 1 : w_dly + 1) : 64'd0);
        chk({tag, ":arvalid_cycles"}, 64'(arv_cyc - arv0),
            wr ? 64'd0 : (ar_never ? 64'(TMO) : 64'(ar_dly + 1)));
    endtask

    initial begin
        int n, rsp0;
        bit wr;
        logic [31:0] a;
        ref_mem[32'h1104] = 32'h55667788;
        ref_mem[32'h1304] = 32'h55555555;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset:ctrl", 64'({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_err}), 64'd0);
        chk("reset:addr", {AWADDR, ARADDR}, 64'd0);
        chk("reset:data", {WDATA, rsp_rdata}, 64'd0);
        reset = 1'b1;
        chk("reset:ready_before_clk", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("reset:ready_after_clk", 64'(cmd_ready), 64'd1);

        // one-cycle-delay slave
        aw_dly = 1; w_dly = 1; b_dly = 0; ar_dly = 1; r_dly = 0;
        run_cmd("wr1000", 1'b1, 32'h1000, 32'hAABBCCDD);
        run_cmd("rd1000", 1'b0, 32'h1000, 32'h0);
        run_cmd("rd1104", 1'b0, 32'h1104, 32'h0);

        // back-to-back, zero-wait slave
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        run_cmd("b2b_wr1200", 1'b1, 32'h1200, 32'h11111111);
        run_cmd("b2b_rd1200", 1'b0, 32'h1200, 32'h0);
        run_cmd("b2b_rd1304", 1'b0, 32'h1304, 32'h0);

        // AR never accepted: timeout
        ar_never = 1'b1;
        run_cmd("tmo_rd", 1'b0, 32'h1104, 32'h0);
        ar_never = 1'b0;
        run_cmd("after_tmo_rd", 1'b0, 32'h1104, 32'h0);

        // reset while waiting in the W phase
        w_never = 1'b1; aw_dly = 0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1400; cmd_wdata = 32'hDEADBEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!WVALID && n < 20) begin @(negedge clk); n++; end
        chk("rstw:reached_wdata", 64'(WVALID), 64'd1);
        rsp0 = rsp_cnt;
        #2 reset = 1'b0;
        #1;
        chk("rstw:ctrl", 64'({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_err}), 64'd0);
        chk("rstw:addr", {AWADDR, ARADDR}, 64'd0);
        chk("rstw:data", {WDATA, rsp_rdata}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        w_never = 1'b0;
        last_rdata = 32'd0;
        @(negedge clk);
        chk("rstw:no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
        run_cmd("rstw_rd1000", 1'b0, 32'h1000, 32'h0);

        // WREADY already high before WVALID
        w_pre = 1'b1; aw_dly = 1; b_dly = 1;
        run_cmd("wpre_wr", 1'b1, 32'h1500, 32'h0BADF00D);
        run_cmd("wpre_rd", 1'b0, 32'h1500, 32'h0);
        w_pre = 1'b0;

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            w_pre = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a = 32'h2000 + 32'(4 * $urandom_range(0, 7));
            run_cmd($sformatf("rand%0d", i), wr, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
